// File: rtl/arrow_board_decoder.sv
// Arrow-board receive-side checker: windows four lamp samples, classifies the
// display mode, debounces the result and flags unclassifiable lamp streams.
module arrow_board_decoder #(
  parameter int unsigned CONFIRM   = 2,  // 1..7
  parameter int unsigned FAULT_LIM = 4   // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en_i,
  input  logic [15:0] lamps_i,
  output logic [15:0] frame_o,
  output logic [1:0]  mode_o,
  output logic        valid_o,
  output logic        changed_o,
  output logic        fault_o
);

  localparam logic [2:0] AGREE_MAX = 3'(CONFIRM);
  localparam logic [3:0] UCNT_MAX  = 4'(FAULT_LIM);

  localparam logic [1:0] MODE_DARK   = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_FLASH  = 2'b10;
  localparam logic [1:0] MODE_SEQ    = 2'b11;

  // sample window, s0 oldest
  logic [15:0] s0_q, s1_q, s2_q, s3_q;
  logic [2:0]  fill_q, fill_d;

  // post-shift window as seen by the evaluation in a sample_en cycle
  logic [15:0] w0, w1, w2, w3;

  // classifier results
  logic        cls_unk;
  logic [1:0]  cls_mode;
  logic [15:0] cls_frame;
  logic        w_const;
  logic        t0, t1, t2, t3;
  logic [2:0]  nsup;

  // debounce / fault state
  logic [18:0] prev_cand_q, cand;
  logic [2:0]  agree_q, agree_d;
  logic [3:0]  ucnt_q, ucnt_d;
  logic        eval;
  logic        load;

  logic [15:0] frame_q;
  logic [1:0]  mode_q;
  logic        valid_q;
  logic        changed_q;

  assign w0 = s1_q;
  assign w1 = s2_q;
  assign w2 = s3_q;
  assign w3 = lamps_i;

  assign eval = sample_en_i && (fill_q >= 3'd3);

  // classify the post-shift window, first matching mode wins
  always_comb begin
    cls_unk   = 1'b1;
    cls_mode  = MODE_DARK;
    cls_frame = w0 | w1 | w2 | w3;
    w_const   = (w0 == w1) && (w1 == w2) && (w2 == w3);
    // a transition counts when the next sample drops a lamp that was lit
    t0 = (w1 & w0) != w0;
    t1 = (w2 & w1) != w1;
    t2 = (w3 & w2) != w2;
    t3 = (w0 & w3) != w3;
    nsup = 3'(t0) + 3'(t1) + 3'(t2) + 3'(t3);
    if (cls_frame == 16'h0000) begin
      cls_unk  = 1'b0;
      cls_mode = MODE_DARK;
    end else if (w_const) begin
      cls_unk  = 1'b0;
      cls_mode = MODE_STEADY;
    end else if ((w0 == w2) && (w1 == w3) && ((w0 == 16'h0000) != (w1 == 16'h0000))) begin
      cls_unk  = 1'b0;
      cls_mode = MODE_FLASH;
    end else if (nsup == 3'd1) begin
      cls_unk  = 1'b0;
      cls_mode = MODE_SEQ;
    end
  end

  // debounce and fault counter next-state
  always_comb begin
    cand    = {cls_unk, cls_mode, cls_frame};
    fill_d  = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    agree_d = agree_q;
    ucnt_d  = ucnt_q;
    load    = 1'b0;
    if (eval) begin
      if (cls_unk) begin
        agree_d = 3'd0;
        ucnt_d  = (ucnt_q == UCNT_MAX) ? UCNT_MAX : ucnt_q + 4'd1;
      end else begin
        ucnt_d = 4'd0;
        if (cand == prev_cand_q) begin
          agree_d = (agree_q >= AGREE_MAX) ? AGREE_MAX : agree_q + 3'd1;
        end else begin
          agree_d = 3'd1;
        end
        load = (agree_d == AGREE_MAX) &&
               (!valid_q || ({mode_q, frame_q} != {cls_mode, cls_frame}));
      end
    end
  end

  // sample window shift register and fill counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      fill_q <= '0;
    end else if (sample_en_i) begin
      s0_q   <= s1_q;
      s1_q   <= s2_q;
      s2_q   <= s3_q;
      s3_q   <= lamps_i;
      fill_q <= fill_d;
    end
  end

  // debounce history; the reset candidate carries the unknown flag so it never matches a real one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cand_q <= {1'b1, 18'h0};
      agree_q     <= '0;
      ucnt_q      <= '0;
    end else if (eval) begin
      prev_cand_q <= cand;
      agree_q     <= agree_d;
      ucnt_q      <= ucnt_d;
    end
  end

  // confirmed outputs and the one-cycle update pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q   <= '0;
      mode_q    <= MODE_DARK;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= load;
      if (load) begin
        frame_q <= cls_frame;
        mode_q  <= cls_mode;
        valid_q <= 1'b1;
      end
    end
  end

  assign frame_o   = frame_q;
  assign mode_o    = mode_q;
  assign valid_o   = valid_q;
  assign changed_o = changed_q;
  assign fault_o   = (ucnt_q == UCNT_MAX);

endmodule

// File: tb/tb_arrow_board_decoder.sv
// Directed bench for arrow_board_decoder with hand-computed expectations.
module tb_arrow_board_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en_i = 1'b0;
  logic [15:0] lamps_i = 16'h0000;
  logic [15:0] frame_o;
  logic [1:0]  mode_o;
  logic        valid_o;
  logic        changed_o;
  logic        fault_o;

  int ncmp = 0;
  int nfail = 0;

  arrow_board_decoder #(.CONFIRM(2), .FAULT_LIM(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en_i (sample_en_i),
    .lamps_i     (lamps_i),
    .frame_o     (frame_o),
    .mode_o      (mode_o),
    .valid_o     (valid_o),
    .changed_o   (changed_o),
    .fault_o     (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] f, input logic [1:0] m,
                         input logic v, input logic c, input logic flt);
    chk({tag, ".frame"},   frame_o,           f);
    chk({tag, ".mode"},    {14'h0, mode_o},    {14'h0, m});
    chk({tag, ".valid"},   {15'h0, valid_o},   {15'h0, v});
    chk({tag, ".changed"}, {15'h0, changed_o}, {15'h0, c});
    chk({tag, ".fault"},   {15'h0, fault_o},   {15'h0, flt});
  endtask

  task automatic smp(input logic [15:0] v);
    lamps_i = v;
    sample_en_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sample_en_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en_i = 1'b0;
    lamps_i = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout ncmp=%0d", ncmp);
    $fatal(1, "timeout");
  end

  initial begin
    // steady 0F0F, with an idle cycle between the first and second eval
    do_reset();
    chk_all("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    smp(16'h0F0F); smp(16'h0F0F); smp(16'h0F0F);
    chk("s1.fill3.valid", {15'h0, valid_o}, 16'h0000);
    smp(16'h0F0F);
    chk_all("s1.eval1", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();
    chk_all("s1.idle", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    smp(16'h0F0F);
    chk_all("s1.eval2", 16'h0F0F, 2'b01, 1'b1, 1'b1, 1'b0);
    smp(16'h0F0F);
    chk_all("s1.hold", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b0);

    // pattern change to F0F0: three mixed windows leave the outputs alone
    for (int i = 0; i < 3; i++) begin
      smp(16'hF0F0);
      chk("s4.mixed.frame", frame_o, 16'h0F0F);
      chk("s4.mixed.changed", {15'h0, changed_o}, 16'h0000);
    end
    chk("s4.mixed.fault", {15'h0, fault_o}, 16'h0000);
    smp(16'hF0F0);
    chk_all("s4.eval1", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b0);
    smp(16'hF0F0);
    chk_all("s4.load", 16'hF0F0, 2'b01, 1'b1, 1'b1, 1'b0);
    smp(16'hF0F0);
    chk("s4.nopulse", {15'h0, changed_o}, 16'h0000);

    // flashing, starting on the lit phase
    do_reset();
    smp(16'h00FF); smp(16'h0000); smp(16'h00FF); smp(16'h0000);
    chk_all("s2a.eval1", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    smp(16'h00FF);
    chk_all("s2a.load", 16'h00FF, 2'b10, 1'b1, 1'b1, 1'b0);

    // flashing, starting on the dark phase
    do_reset();
    smp(16'h0000); smp(16'h00FF); smp(16'h0000); smp(16'h00FF);
    chk("s2b.eval1.valid", {15'h0, valid_o}, 16'h0000);
    smp(16'h0000);
    chk_all("s2b.load", 16'h00FF, 2'b10, 1'b1, 1'b1, 1'b0);

    // sequential from the start of the cycle
    do_reset();
    smp(16'h0001); smp(16'h0003); smp(16'h0007); smp(16'h000F);
    chk("s3a.eval1.valid", {15'h0, valid_o}, 16'h0000);
    smp(16'h0001);
    chk_all("s3a.load", 16'h000F, 2'b11, 1'b1, 1'b1, 1'b0);

    // sequential entered mid-cycle
    do_reset();
    smp(16'h0007); smp(16'h000F); smp(16'h0001); smp(16'h0003);
    chk("s3b.eval1.valid", {15'h0, valid_o}, 16'h0000);
    smp(16'h0007);
    chk_all("s3b.load", 16'h000F, 2'b11, 1'b1, 1'b1, 1'b0);

    // fault: confirmed steady, then walking-one junk that fits no mode
    do_reset();
    smp(16'h0F0F); smp(16'h0F0F); smp(16'h0F0F); smp(16'h0F0F); smp(16'h0F0F);
    chk("s5.pre.valid", {15'h0, valid_o}, 16'h0001);
    smp(16'h0010); smp(16'h0020); smp(16'h0040);
    chk("s5.junk3.fault", {15'h0, fault_o}, 16'h0000);
    smp(16'h0080);
    chk_all("s5.junk4", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b1);
    smp(16'h1000); smp(16'h2000); smp(16'h4000); smp(16'h8000);
    chk_all("s5.junk8", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b1);
    smp(16'h0000); smp(16'h0000);
    chk("s5.zero2.fault", {15'h0, fault_o}, 16'h0001);
    // window 8000,0,0,0 is a legal sequential decay, so the fault clears here
    smp(16'h0000);
    chk_all("s5.zero3", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b0);
    smp(16'h0000);
    chk_all("s5.zero4", 16'h0F0F, 2'b01, 1'b1, 1'b0, 1'b0);
    smp(16'h0000);
    chk_all("s5.zero5", 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // asynchronous reset in the middle of a sequential display
    do_reset();
    smp(16'h0001); smp(16'h0003); smp(16'h0007); smp(16'h000F); smp(16'h0001);
    chk_all("s6.pre", 16'h000F, 2'b11, 1'b1, 1'b1, 1'b0);
    sample_en_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("s6.async", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    smp(16'h0007); smp(16'h000F); smp(16'h0001);
    chk("s6.fill3.valid", {15'h0, valid_o}, 16'h0000);
    smp(16'h0003);
    chk_all("s6.eval1", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    smp(16'h0007);
    chk_all("s6.load", 16'h000F, 2'b11, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
